// File: rtl/cnn_result_collector_pkg.sv
// Shared types and record layout for the CNN result collector.
// Record width depends on RESULT_LOWCONF_EN (adds a stored low-confidence bit).
package cnn_result_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

`ifdef RESULT_LOWCONF_EN
  localparam int unsigned LOWCONF_BITS = 1;
`else
  localparam int unsigned LOWCONF_BITS = 0;
`endif

  // Record layout, LSB first: frame index, margin, class, [lowconf]
  function automatic int unsigned margin_w(input int unsigned data_w);
    return data_w + 1;
  endfunction

  function automatic int unsigned margin_lsb(input int unsigned frame_w);
    return frame_w;
  endfunction

  function automatic int unsigned class_bit(input int unsigned data_w, input int unsigned frame_w);
    return frame_w + data_w + 1;
  endfunction

  function automatic int unsigned lowconf_bit(input int unsigned data_w, input int unsigned frame_w);
    return frame_w + data_w + 2;
  endfunction

  function automatic int unsigned record_w(input int unsigned data_w, input int unsigned frame_w);
    return 1 + (data_w + 1) + frame_w + LOWCONF_BITS;
  endfunction

endpackage

// File: rtl/cnn_result_collector_if.sv
// Result record stream (ready/valid) from the collector to its sink.
interface cnn_result_collector_if #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned FRAME_W = 10
);
  logic               res_valid_o;
  logic               res_ready_i;
  logic               res_class_o;
  logic [DATA_W:0]    res_margin_o;
  logic [FRAME_W-1:0] res_frame_o;
  logic               res_lowconf_o;

  modport master (
    output res_valid_o, res_class_o, res_margin_o, res_frame_o, res_lowconf_o,
    input  res_ready_i
  );

  modport slave (
    input  res_valid_o, res_class_o, res_margin_o, res_frame_o, res_lowconf_o,
    output res_ready_i
  );
endinterface

// File: rtl/cnn_result_collector_fifo.sv
// Synchronous FIFO with extra pointer MSB for full/empty; head read from registered storage.
// A pop in the same cycle frees a slot, so a push into a full FIFO is accepted.
module result_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/cnn_result_collector.sv
// CNN result collector: argmax/margin per frame, record FIFO, batch FSM, counters, sticky flags.
// Optional feature macro: RESULT_LOWCONF_EN (stored low-confidence flag, excluded from class-1 count).
module cnn_result_collector
  import cnn_result_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned FRAME_W = 10,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sta_i,
  input  logic [FRAME_W-1:0]     batch_len_i,
  input  logic                   clr_i,
  input  logic                   valid_i,
  input  logic [DATA_W-1:0]      data1_i,
  input  logic [DATA_W-1:0]      data2_i,
  input  logic [DATA_W:0]        thresh_i,
  cnn_result_collector_if.master res,
  output logic                   busy_o,
  output logic                   batch_done_o,
  output logic [CNT_W-1:0]       class1_cnt_o,
  output logic                   overflow_o,
  output logic                   stray_o
);
  localparam int unsigned MW = margin_w(DATA_W);
  localparam int unsigned ML = margin_lsb(FRAME_W);
  localparam int unsigned CB = class_bit(DATA_W, FRAME_W);
  localparam int unsigned RW = record_w(DATA_W, FRAME_W);

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] frame_idx;
  logic [FRAME_W-1:0] last_idx;
  logic               arm;
  logic               frame_fire;
  logic               stray_hit;

  // Decision and margin, evaluated one bit wider so extreme scores cannot wrap
  logic signed [MW-1:0] s1, s2;
  logic                 cls;
  logic [MW-1:0]        margin;
  logic                 count_ok;
  logic [RW-1:0]        rec_in, rec_head;

  assign s1     = {data1_i[DATA_W-1], data1_i};
  assign s2     = {data2_i[DATA_W-1], data2_i};
  assign cls    = (s2 > s1);
  assign margin = cls ? $unsigned(s2 - s1) : $unsigned(s1 - s2);

`ifdef RESULT_LOWCONF_EN
  logic lowconf;
  assign lowconf  = (margin < thresh_i);
  assign count_ok = cls & ~lowconf;
  assign rec_in   = {lowconf, cls, margin, frame_idx};
  assign res.res_lowconf_o = rec_head[lowconf_bit(DATA_W, FRAME_W)];
`else
  logic unused_thresh;
  assign unused_thresh     = ^thresh_i;
  assign count_ok          = cls;
  assign rec_in            = {cls, margin, frame_idx};
  assign res.res_lowconf_o = 1'b0;
`endif

  logic fifo_full, fifo_empty;
  logic pop_fire, push_ok, drop;

  assign pop_fire = ~fifo_empty & res.res_ready_i;
  assign push_ok  = frame_fire & (~fifo_full | pop_fire);
  assign drop     = frame_fire & fifo_full & ~pop_fire;

  result_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_i),
    .push  (frame_fire),
    .pop   (res.res_ready_i),
    .din   (rec_in),
    .dout  (rec_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign res.res_valid_o  = ~fifo_empty;
  assign res.res_frame_o  = rec_head[FRAME_W-1:0];
  assign res.res_margin_o = rec_head[ML +: MW];
  assign res.res_class_o  = rec_head[CB];

  always_comb begin
    state_d    = state_q;
    arm        = 1'b0;
    frame_fire = 1'b0;
    stray_hit  = valid_i & (state_q != RUN);
    case (state_q)
      IDLE: if (sta_i && batch_len_i != '0) begin
        state_d = RUN;
        arm     = 1'b1;
      end
      RUN: if (valid_i) begin
        frame_fire = 1'b1;
        if (frame_idx == last_idx) state_d = DONE;
      end
      DONE: if (fifo_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Clear overrides everything happening in the same cycle
    if (clr_i) begin
      state_d    = IDLE;
      arm        = 1'b0;
      frame_fire = 1'b0;
      stray_hit  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_idx    <= '0;
      last_idx     <= '0;
      class1_cnt_o <= '0;
      overflow_o   <= 1'b0;
      stray_o      <= 1'b0;
    end else if (clr_i) begin
      frame_idx    <= '0;
      class1_cnt_o <= '0;
      overflow_o   <= 1'b0;
      stray_o      <= 1'b0;
    end else begin
      if (arm) begin
        frame_idx <= '0;
        last_idx  <= batch_len_i - FRAME_W'(1);
      end
      if (frame_fire) frame_idx <= frame_idx + FRAME_W'(1);
      if (drop) overflow_o <= 1'b1;
      if (stray_hit) stray_o <= 1'b1;
      if (push_ok && count_ok && class1_cnt_o != '1)
        class1_cnt_o <= class1_cnt_o + CNT_W'(1);
    end
  end

  assign busy_o       = (state_q == RUN);
  assign batch_done_o = (state_q == DONE);
endmodule

// File: tb/tb_cnn_result_collector.sv
// Directed bench for cnn_result_collector: vector table plus multi-cycle corner sequences.
module tb_cnn_result_collector;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned FRAME_W = 10;
  localparam int unsigned CNT_W   = 16;
`ifdef RESULT_LOWCONF_EN
  localparam bit LC_EN = 1'b1;
`else
  localparam bit LC_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               sta_i;
  logic [FRAME_W-1:0] batch_len_i;
  logic               clr_i;
  logic               valid_i;
  logic [DATA_W-1:0]  data1_i, data2_i;
  logic [DATA_W:0]    thresh_i;
  logic               busy_o, batch_done_o, overflow_o, stray_o;
  logic [CNT_W-1:0]   class1_cnt_o;

  cnn_result_collector_if #(.DATA_W(DATA_W), .FRAME_W(FRAME_W)) res_if ();

  cnn_result_collector #(
    .DATA_W (DATA_W), .DEPTH (DEPTH), .FRAME_W (FRAME_W), .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sta_i        (sta_i),
    .batch_len_i  (batch_len_i),
    .clr_i        (clr_i),
    .valid_i      (valid_i),
    .data1_i      (data1_i),
    .data2_i      (data2_i),
    .thresh_i     (thresh_i),
    .res          (res_if),
    .busy_o       (busy_o),
    .batch_done_o (batch_done_o),
    .class1_cnt_o (class1_cnt_o),
    .overflow_o   (overflow_o),
    .stray_o      (stray_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [DATA_W-1:0] d1;
    logic signed [DATA_W-1:0] d2;
    logic                     cls;
    logic [DATA_W:0]          margin;
    logic                     lc;
  } vec_t;

  vec_t vecs [8];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int len);
    sta_i       = 1'b1;
    batch_len_i = FRAME_W'(len);
    tick();
    sta_i = 1'b0;
  endtask

  task automatic send(input logic signed [DATA_W-1:0] a, input logic signed [DATA_W-1:0] b);
    data1_i = a;
    data2_i = b;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic do_clear();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{d1:  10, d2:   -5, cls: 0, margin:  15, lc: 0};
    vecs[1] = '{d1:  -3, d2:    7, cls: 1, margin:  10, lc: 0};
    vecs[2] = '{d1:   4, d2:    4, cls: 0, margin:   0, lc: 1};
    vecs[3] = '{d1:-128, d2:  127, cls: 1, margin: 255, lc: 0};
    vecs[4] = '{d1: 127, d2: -128, cls: 0, margin: 255, lc: 0};
    vecs[5] = '{d1:   3, d2:    6, cls: 1, margin:   3, lc: 1};
    vecs[6] = '{d1:  -1, d2:    0, cls: 1, margin:   1, lc: 1};
    vecs[7] = '{d1:   0, d2:   -1, cls: 0, margin:   1, lc: 1};

    rst = 1'b1; sta_i = 1'b0; batch_len_i = '0; clr_i = 1'b0; valid_i = 1'b0;
    data1_i = '0; data2_i = '0; thresh_i = 9'd5; res_if.res_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_valid",    res_if.res_valid_o, 0);
    check("reset_busy",     busy_o, 0);
    check("reset_done",     batch_done_o, 0);
    check("reset_cnt",      class1_cnt_o, 0);
    check("reset_overflow", overflow_o, 0);
    check("reset_stray",    stray_o, 0);
    check("reset_frame",    res_if.res_frame_o, 0);
    check("reset_margin",   res_if.res_margin_o, 0);

    // Zero-length start is ignored
    start(0);
    check("len0_busy", busy_o, 0);

    // Vector table: one frame every two cycles, ready held high
    res_if.res_ready_i = 1'b1;
    start(8);
    check("start_busy", busy_o, 1);
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].d1, vecs[i].d2);
      if (vecs[i].cls && !(LC_EN && vecs[i].lc)) exp_cnt++;
      check($sformatf("vec%0d_valid", i),   res_if.res_valid_o, 1);
      check($sformatf("vec%0d_class", i),   res_if.res_class_o, vecs[i].cls);
      check($sformatf("vec%0d_margin", i),  res_if.res_margin_o, vecs[i].margin);
      check($sformatf("vec%0d_frame", i),   res_if.res_frame_o, i);
      check($sformatf("vec%0d_lowconf", i), res_if.res_lowconf_o, LC_EN & vecs[i].lc);
      check($sformatf("vec%0d_cnt", i),     class1_cnt_o, exp_cnt);
      check($sformatf("vec%0d_done", i),    batch_done_o, (i == 7));
      tick();
    end
    check("tbl_done_empty", batch_done_o, 1);
    check("tbl_empty",      res_if.res_valid_o, 0);
    tick();
    check("tbl_idle_done",  batch_done_o, 0);
    check("tbl_idle_busy",  busy_o, 0);

    // Stray valid in IDLE, then clear
    send(8'sd1, 8'sd2);
    check("stray_set",   stray_o, 1);
    check("stray_novld", res_if.res_valid_o, 0);
    check("stray_cnt",   class1_cnt_o, exp_cnt);
    do_clear();
    check("clr_stray", stray_o, 0);
    check("clr_cnt",   class1_cnt_o, 0);

    // Overflow: ready low, 10 frames back to back
    res_if.res_ready_i = 1'b0;
    start(10);
    for (int i = 0; i < 10; i++) begin
      data1_i = 8'sd0; data2_i = 8'sd20; valid_i = 1'b1;
      tick();
      if (i == 7) check("ovf_before", overflow_o, 0);
      if (i == 8) check("ovf_set",    overflow_o, 1);
    end
    valid_i = 1'b0;
    check("ovf_done", batch_done_o, 1);
    check("ovf_cnt",  class1_cnt_o, 8);
    check("ovf_head", res_if.res_frame_o, 0);
    res_if.res_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d_valid", i), res_if.res_valid_o, 1);
      check($sformatf("drain%0d_frame", i), res_if.res_frame_o, i);
      tick();
    end
    check("drain_empty", res_if.res_valid_o, 0);
    tick();
    check("drain_idle", batch_done_o, 0);
    do_clear();
    check("clr_ovf", overflow_o, 0);

    // Full FIFO with same-cycle pop and push: nothing dropped
    res_if.res_ready_i = 1'b0;
    start(10);
    for (int i = 0; i < 8; i++) send(8'sd5, 8'sd1);
    data1_i = 8'sd5; data2_i = 8'sd1; valid_i = 1'b1; res_if.res_ready_i = 1'b1;
    tick();
    valid_i = 1'b0;
    check("pp_ovf",  overflow_o, 0);
    check("pp_busy", busy_o, 1);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("pp%0d_frame", i),  res_if.res_frame_o, i);
      check($sformatf("pp%0d_margin", i), res_if.res_margin_o, 4);
      tick();
    end
    check("pp_empty", res_if.res_valid_o, 0);
    do_clear();

    // Reset mid-batch with three queued records
    res_if.res_ready_i = 1'b0;
    start(5);
    for (int i = 0; i < 3; i++) send(8'sd2, 8'sd9);
    check("mid_cnt",   class1_cnt_o, 3);
    check("mid_valid", res_if.res_valid_o, 1);
    rst = 1'b1;
    #1;
    check("rst_valid", res_if.res_valid_o, 0);
    check("rst_busy",  busy_o, 0);
    check("rst_cnt",   class1_cnt_o, 0);
    check("rst_frame", res_if.res_frame_o, 0);
    check("rst_class", res_if.res_class_o, 0);
    tick();
    rst = 1'b0;
    res_if.res_ready_i = 1'b1;
    start(1);
    send(-8'sd7, -8'sd9);
    check("post_valid",  res_if.res_valid_o, 1);
    check("post_frame",  res_if.res_frame_o, 0);
    check("post_class",  res_if.res_class_o, 0);
    check("post_margin", res_if.res_margin_o, 2);
    check("post_done",   batch_done_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
